// File: rtl/hpdcache_l15_adapter_pkg.sv
// Shared encodings, FIFO entry type and byte-swap helper for the
// HPDcache to OpenPiton L1.5 adapter.
package hpdcache_l15_adapter_pkg;

    localparam logic [4:0] RQ_LOAD  = 5'b00000;
    localparam logic [4:0] RQ_STORE = 5'b00001;

    localparam logic [3:0] RET_LOAD   = 4'b0000;
    localparam logic [3:0] RET_ST_ACK = 4'b0100;

    localparam logic [2:0] SIZE_1B  = 3'b000;
    localparam logic [2:0] SIZE_2B  = 3'b001;
    localparam logic [2:0] SIZE_4B  = 3'b010;
    localparam logic [2:0] SIZE_8B  = 3'b011;
    localparam logic [2:0] SIZE_16B = 3'b111;

    // Widest TID the entry can hold; the top narrows it to TidWidth.
    localparam int TXN_TID_W = 8;

    typedef struct packed {
        logic [TXN_TID_W-1:0] tid;
        logic                 is_store;
    } txn_t;

    typedef enum logic {
        S_IDLE,
        S_WAIT_ACK
    } req_state_e;

    // Byte i of the word moves to byte 7-i when en is set.
    function automatic logic [63:0] bswap64(input logic [63:0] d,
                                            input logic        en);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = d[8*(7-i) +: 8];
        end
        return en ? r : d;
    endfunction

endpackage

// File: rtl/hpdcache_l15_adapter_txn_fifo.sv
// In-order outstanding-transaction FIFO with occupancy count.
// Ports: clk/rst, push+din, pop+dout (head), count, full, empty.
module hpdcache_l15_txn_fifo #(
    parameter int Width = 9,
    parameter int Depth = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [Width-1:0]       din,
    input  logic                   pop,
    output logic [Width-1:0]       dout,
    output logic [$clog2(Depth):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth) + 1;

    logic [Width-1:0] mem [Depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(Depth));
    assign empty = (count == '0);

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/hpdcache_l15_adapter.sv
// HPDcache memory interface to OpenPiton L1.5 request/return adapter.
// Ports: req_* (HPDcache request in), l15_* (L1.5 header out, return in),
// rsp_r_*/rsp_w_* (HPDcache read/write responses), err_o (sticky error).
module hpdcache_l15_adapter
    import hpdcache_l15_adapter_pkg::*;
#(
    parameter int AddrWidth      = 40,
    parameter int TidWidth       = 2,
    parameter int MaxOutstanding = 4,
    parameter bit SwapEndian     = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_is_store_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [2:0]           req_size_i,
    input  logic [TidWidth-1:0]  req_tid_i,
    input  logic                 req_cacheable_i,
    input  logic [63:0]          req_wdata_i,
    output logic                 l15_val_o,
    output logic [4:0]           l15_rqtype_o,
    output logic [2:0]           l15_size_o,
    output logic [AddrWidth-1:0] l15_address_o,
    output logic                 l15_nc_o,
    output logic [63:0]          l15_data_o,
    input  logic                 l15_header_ack_i,
    input  logic                 l15_ret_val_i,
    input  logic [3:0]           l15_ret_type_i,
    input  logic [127:0]         l15_ret_data_i,
    output logic                 l15_req_ack_o,
    output logic                 rsp_r_valid_o,
    output logic [TidWidth-1:0]  rsp_r_tid_o,
    output logic [127:0]         rsp_r_data_o,
    output logic                 rsp_w_valid_o,
    output logic [TidWidth-1:0]  rsp_w_tid_o,
    output logic                 err_o
);

    localparam int CW = $clog2(MaxOutstanding) + 1;

    req_state_e    state;
    req_state_e    state_nxt;
    txn_t          push_entry;
    txn_t          head;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          accept;
    logic          known_ret;
    logic          is_ld_ret;
    logic          pop;
    logic          rsp_r_set;
    logic          rsp_w_set;
    logic          err_set;

    assign req_ready_o = (state == S_IDLE) && !full;
    assign accept      = req_valid_i && req_ready_o;
    assign l15_val_o   = (state == S_WAIT_ACK);

    assign push_entry.tid      = TXN_TID_W'(req_tid_i);
    assign push_entry.is_store = req_is_store_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:     if (accept)           state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: if (l15_header_ack_i) state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            l15_rqtype_o  <= '0;
            l15_size_o    <= '0;
            l15_address_o <= '0;
            l15_nc_o      <= 1'b0;
            l15_data_o    <= '0;
        end else if (accept) begin
            l15_rqtype_o  <= req_is_store_i ? RQ_STORE : RQ_LOAD;
            l15_size_o    <= req_size_i;
            l15_address_o <= req_addr_i;
            l15_nc_o      <= !req_cacheable_i;
            l15_data_o    <= bswap64(req_wdata_i, SwapEndian);
        end
    end

    hpdcache_l15_txn_fifo #(
        .Width ($bits(txn_t)),
        .Depth (MaxOutstanding)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (accept),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Returns are always consumed; unknown types never touch the FIFO.
    assign l15_req_ack_o = l15_ret_val_i;
    assign is_ld_ret     = (l15_ret_type_i == RET_LOAD);
    assign known_ret     = is_ld_ret || (l15_ret_type_i == RET_ST_ACK);
    assign pop           = l15_ret_val_i && known_ret && !empty;
    assign rsp_r_set     = pop && is_ld_ret && !head.is_store;
    assign rsp_w_set     = pop && !is_ld_ret && head.is_store;
    // Mismatch: load return on a store head, or store ack on a load head.
    assign err_set       = l15_ret_val_i && known_ret &&
                           (empty || (is_ld_ret == head.is_store));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_r_valid_o <= 1'b0;
            rsp_r_tid_o   <= '0;
            rsp_r_data_o  <= '0;
            rsp_w_valid_o <= 1'b0;
            rsp_w_tid_o   <= '0;
            err_o         <= 1'b0;
        end else begin
            rsp_r_valid_o <= rsp_r_set;
            rsp_w_valid_o <= rsp_w_set;
            if (rsp_r_set) begin
                rsp_r_tid_o  <= TidWidth'(head.tid);
                rsp_r_data_o <= {bswap64(l15_ret_data_i[127:64], SwapEndian),
                                 bswap64(l15_ret_data_i[63:0], SwapEndian)};
            end
            if (rsp_w_set) rsp_w_tid_o <= TidWidth'(head.tid);
            if (err_set)   err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hpdcache_l15_adapter.sv
// Self-checking bench for hpdcache_l15_adapter: table of single
// transactions plus hand-written full-FIFO, error and reset sequences.
module tb_hpdcache_l15_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_is_store;
    logic [39:0]  req_addr;
    logic [2:0]   req_size;
    logic [1:0]   req_tid;
    logic         req_cacheable;
    logic [63:0]  req_wdata;
    logic         l15_val;
    logic [4:0]   l15_rqtype;
    logic [2:0]   l15_size;
    logic [39:0]  l15_address;
    logic         l15_nc;
    logic [63:0]  l15_data;
    logic         l15_header_ack;
    logic         l15_ret_val;
    logic [3:0]   l15_ret_type;
    logic [127:0] l15_ret_data;
    logic         l15_req_ack;
    logic         rsp_r_valid;
    logic [1:0]   rsp_r_tid;
    logic [127:0] rsp_r_data;
    logic         rsp_w_valid;
    logic [1:0]   rsp_w_tid;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hpdcache_l15_adapter dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_is_store_i   (req_is_store),
        .req_addr_i       (req_addr),
        .req_size_i       (req_size),
        .req_tid_i        (req_tid),
        .req_cacheable_i  (req_cacheable),
        .req_wdata_i      (req_wdata),
        .l15_val_o        (l15_val),
        .l15_rqtype_o     (l15_rqtype),
        .l15_size_o       (l15_size),
        .l15_address_o    (l15_address),
        .l15_nc_o         (l15_nc),
        .l15_data_o       (l15_data),
        .l15_header_ack_i (l15_header_ack),
        .l15_ret_val_i    (l15_ret_val),
        .l15_ret_type_i   (l15_ret_type),
        .l15_ret_data_i   (l15_ret_data),
        .l15_req_ack_o    (l15_req_ack),
        .rsp_r_valid_o    (rsp_r_valid),
        .rsp_r_tid_o      (rsp_r_tid),
        .rsp_r_data_o     (rsp_r_data),
        .rsp_w_valid_o    (rsp_w_valid),
        .rsp_w_tid_o      (rsp_w_tid),
        .err_o            (err)
    );

    typedef struct {
        logic         st;
        logic [39:0]  addr;
        logic [2:0]   size;
        logic [1:0]   tid;
        logic         cach;
        logic [63:0]  wdata;
        int           ack_dly;
        logic [3:0]   rtype;
        logic [127:0] rdata;
        logic [4:0]   e_rq;
        logic [63:0]  e_data;
        logic         e_nc;
        logic         e_r;
        logic         e_w;
        logic [127:0] e_rdata;
    } vec_t;

    vec_t tv [4];

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic st, input logic [39:0] addr,
                           input logic [2:0] size, input logic [1:0] tid,
                           input logic cach, input logic [63:0] wdata);
        req_valid     = 1'b1;
        req_is_store  = st;
        req_addr      = addr;
        req_size      = size;
        req_tid       = tid;
        req_cacheable = cach;
        req_wdata     = wdata;
    endtask

    task automatic do_req(input logic st, input logic [39:0] addr,
                          input logic [2:0] size, input logic [1:0] tid,
                          input logic cach, input logic [63:0] wdata);
        set_req(st, addr, size, tid, cach, wdata);
        step();
        req_valid = 1'b0;
    endtask

    task automatic do_req_ack(input logic st, input logic [1:0] tid);
        do_req(st, 40'h10_0000_0000, 3'b011, tid, 1'b1, 64'h0);
        l15_header_ack = 1'b1;
        step();
        l15_header_ack = 1'b0;
    endtask

    task automatic ret(input logic [3:0] rtype, input logic [127:0] data);
        l15_ret_val  = 1'b1;
        l15_ret_type = rtype;
        l15_ret_data = data;
        #1;
        chk1("ret_req_ack", l15_req_ack, 1'b1);
        @(posedge clk);
        #1;
        l15_ret_val = 1'b0;
    endtask

    initial begin
        tv[0] = '{st:1'b0, addr:40'h00_8000_0040, size:3'b011, tid:2'd2,
                  cach:1'b1, wdata:64'h0, ack_dly:2, rtype:4'b0000,
                  rdata:{64'h8899aabbccddeeff, 64'h0011223344556677},
                  e_rq:5'b00000, e_data:64'h0, e_nc:1'b0, e_r:1'b1,
                  e_w:1'b0,
                  e_rdata:{64'hffeeddccbbaa9988, 64'h7766554433221100}};
        tv[1] = '{st:1'b1, addr:40'h00_1234_5678, size:3'b011, tid:2'd1,
                  cach:1'b0, wdata:64'h0102030405060708, ack_dly:0,
                  rtype:4'b0100, rdata:128'h0, e_rq:5'b00001,
                  e_data:64'h0807060504030201, e_nc:1'b1, e_r:1'b0,
                  e_w:1'b1, e_rdata:128'h0};
        tv[2] = '{st:1'b1, addr:40'h00_0000_0003, size:3'b000, tid:2'd3,
                  cach:1'b1, wdata:64'h00000000000000ab, ack_dly:1,
                  rtype:4'b0100, rdata:128'h0, e_rq:5'b00001,
                  e_data:64'hab00000000000000, e_nc:1'b0, e_r:1'b0,
                  e_w:1'b1, e_rdata:128'h0};
        tv[3] = '{st:1'b0, addr:40'hff_ffff_fff0, size:3'b111, tid:2'd0,
                  cach:1'b0, wdata:64'h1122334455667788, ack_dly:3,
                  rtype:4'b0000, rdata:{64'h0, 64'hdeadbeef01234567},
                  e_rq:5'b00000, e_data:64'h8877665544332211, e_nc:1'b1,
                  e_r:1'b1, e_w:1'b0,
                  e_rdata:{64'h0, 64'h67452301efbeadde}};

        rst            = 1'b1;
        req_valid      = 1'b0;
        req_is_store   = 1'b0;
        req_addr       = '0;
        req_size       = '0;
        req_tid        = '0;
        req_cacheable  = 1'b1;
        req_wdata      = '0;
        l15_header_ack = 1'b0;
        l15_ret_val    = 1'b0;
        l15_ret_type   = '0;
        l15_ret_data   = '0;
        step();
        step();
        rst = 1'b0;
        step();

        chk1("rst_ready", req_ready, 1'b1);
        chk1("rst_val", l15_val, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_rsp_r", rsp_r_valid, 1'b0);
        chk1("rst_rsp_w", rsp_w_valid, 1'b0);
        chk1("rst_req_ack", l15_req_ack, 1'b0);
        chk("rst_data", 128'(l15_data), 128'h0);

        for (int k = 0; k < 4; k++) begin
            chk1("tv_ready", req_ready, 1'b1);
            do_req(tv[k].st, tv[k].addr, tv[k].size, tv[k].tid,
                   tv[k].cach, tv[k].wdata);
            chk1("tv_val_rise", l15_val, 1'b1);
            chk("tv_rqtype", 128'(l15_rqtype), 128'(tv[k].e_rq));
            chk("tv_size", 128'(l15_size), 128'(tv[k].size));
            chk("tv_addr", 128'(l15_address), 128'(tv[k].addr));
            chk1("tv_nc", l15_nc, tv[k].e_nc);
            chk("tv_data", 128'(l15_data), 128'(tv[k].e_data));
            for (int c = 0; c < tv[k].ack_dly; c++) begin
                step();
                chk1("tv_val_hold", l15_val, 1'b1);
                chk("tv_addr_hold", 128'(l15_address), 128'(tv[k].addr));
            end
            l15_header_ack = 1'b1;
            step();
            l15_header_ack = 1'b0;
            chk1("tv_val_drop", l15_val, 1'b0);
            ret(tv[k].rtype, tv[k].rdata);
            chk1("tv_rsp_r", rsp_r_valid, tv[k].e_r);
            chk1("tv_rsp_w", rsp_w_valid, tv[k].e_w);
            if (tv[k].e_r) begin
                chk("tv_rtid", 128'(rsp_r_tid), 128'(tv[k].tid));
                chk("tv_rdata", rsp_r_data, tv[k].e_rdata);
            end
            if (tv[k].e_w) begin
                chk("tv_wtid", 128'(rsp_w_tid), 128'(tv[k].tid));
            end
            step();
            chk1("tv_pulse_r", rsp_r_valid, 1'b0);
            chk1("tv_pulse_w", rsp_w_valid, 1'b0);
            chk1("tv_err", err, 1'b0);
        end

        // Fill the FIFO, hold a fifth request, free one slot.
        for (int i = 0; i < 4; i++) begin
            chk1("fill_ready", req_ready, 1'b1);
            do_req_ack(1'b0, 2'(i));
        end
        chk1("full_ready", req_ready, 1'b0);
        set_req(1'b1, 40'h00_0000_0100, 3'b011, 2'd2, 1'b1,
                64'h0102030405060708);
        step();
        step();
        chk1("held_val", l15_val, 1'b0);
        ret(4'b0010, 128'h0);
        chk1("unk_rsp_r", rsp_r_valid, 1'b0);
        chk1("unk_rsp_w", rsp_w_valid, 1'b0);
        chk1("unk_err", err, 1'b0);
        chk1("unk_ready", req_ready, 1'b0);
        l15_ret_val  = 1'b1;
        l15_ret_type = 4'b0000;
        l15_ret_data = 128'h0;
        #1;
        chk1("pop_same_ready", req_ready, 1'b0);
        @(posedge clk);
        #1;
        l15_ret_val = 1'b0;
        chk1("full_pop_rsp", rsp_r_valid, 1'b1);
        chk("full_pop_tid", 128'(rsp_r_tid), 128'd0);
        chk1("after_pop_ready", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        chk1("fifth_val", l15_val, 1'b1);
        chk("fifth_rqtype", 128'(l15_rqtype), 128'(5'b00001));
        l15_header_ack = 1'b1;
        step();
        l15_header_ack = 1'b0;
        for (int i = 1; i < 4; i++) begin
            ret(4'b0000, 128'h0);
            chk1("drain_rsp_r", rsp_r_valid, 1'b1);
            chk("drain_tid", 128'(rsp_r_tid), 128'(i));
        end
        ret(4'b0100, 128'h0);
        chk1("drain_rsp_w", rsp_w_valid, 1'b1);
        chk("drain_wtid", 128'(rsp_w_tid), 128'd2);
        chk1("drain_err", err, 1'b0);
        step();

        // Return with nothing outstanding.
        ret(4'b0000, 128'h0);
        chk1("empty_rsp_r", rsp_r_valid, 1'b0);
        chk1("empty_rsp_w", rsp_w_valid, 1'b0);
        chk1("empty_err", err, 1'b1);
        step();
        chk1("empty_err_sticky", err, 1'b1);

        // Reset during WAIT_ACK with two entries outstanding.
        do_req_ack(1'b0, 2'd0);
        do_req(1'b0, 40'h00_0000_0200, 3'b011, 2'd1, 1'b1, 64'h0);
        chk1("pre_rst_val", l15_val, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("async_val", l15_val, 1'b0);
        chk1("async_err", err, 1'b0);
        step();
        rst = 1'b0;
        step();
        chk1("post_rst_ready", req_ready, 1'b1);
        chk1("post_rst_err", err, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk1("post_rst_fill", req_ready, 1'b1);
            do_req_ack(1'b0, 2'(i));
        end
        chk1("post_rst_full", req_ready, 1'b0);

        // Store ack against a load head.
        ret(4'b0100, 128'h0);
        chk1("mis_rsp_r", rsp_r_valid, 1'b0);
        chk1("mis_rsp_w", rsp_w_valid, 1'b0);
        chk1("mis_err", err, 1'b1);
        chk1("mis_ready", req_ready, 1'b1);
        for (int i = 1; i < 4; i++) begin
            ret(4'b0000, 128'h0);
            chk1("mis_drain_rsp", rsp_r_valid, 1'b1);
            chk("mis_drain_tid", 128'(rsp_r_tid), 128'(i));
        end
        step();
        chk1("mis_err_sticky", err, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
